// File: rtl/store_array_pkg.sv
// Shared types and helpers for the store_array slice: FSM state encoding,
// column-pointer width and the row/column to output-bit index mapping.
package store_array_pkg;

  typedef enum logic [0:0] {
    ST_LOAD   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  // Pointer width never drops below one bit, so a single-column array still has a port.
  function automatic int ptr_width(input int cols);
    return (cols <= 1) ? 1 : $clog2(cols);
  endfunction

  function automatic int bit_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/store_array_col.sv
// One ROWS-wide column register with synchronous clear and write enable.
// Used both for the visible matrix and for the optional shadow copy.
module store_array_col #(
  parameter int ROWS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            we,
  input  logic [ROWS-1:0] d,
  output logic [ROWS-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/store_array.sv
// ROWS x COLS bit-matrix store loaded one column per beat, committed per frame.
// Define STORE_ARRAY_SHADOW_EN to stage beats in a shadow copy and update out atomically.
module store_array
  import store_array_pkg::*;
#(
  parameter int  ROWS = 2,
  parameter int  COLS = 2,
  localparam int PW   = ptr_width(COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROWS-1:0]      dat,
  input  logic                 dat_valid,
  output logic                 dat_ready,
  input  logic                 restart,
  input  logic                 clr,
  output logic [PW-1:0]        col_ptr,
  output logic                 load_done,
  output logic [ROWS*COLS-1:0] out,
  output state_t               state_dbg
);

  // Handshake: a beat transfers on a rising edge where dat_valid && dat_ready.
  // dat_ready depends only on state and restart, never on dat_valid.
  state_t          state;
  logic            accept;
  logic            last_col;
  logic [ROWS-1:0] col_q [COLS];

  assign dat_ready = (state == ST_LOAD) && !restart;
  assign accept    = dat_valid && dat_ready;
  assign last_col  = (col_ptr == PW'(COLS - 1));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state     <= ST_LOAD;
      col_ptr   <= '0;
      load_done <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          load_done <= 1'b0;
          if (restart) begin
            col_ptr <= '0;
          end else if (accept) begin
            if (last_col) begin
              col_ptr   <= '0;
              state     <= ST_COMMIT;
              load_done <= 1'b1;
            end else begin
              col_ptr <= col_ptr + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          state     <= ST_LOAD;
          load_done <= 1'b0;
        end
        default: begin
          state     <= ST_LOAD;
          load_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_ARRAY_SHADOW_EN
  logic            commit;
  logic [ROWS-1:0] shadow_q [COLS];

  assign commit = (state == ST_COMMIT);
`endif

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic wr;
    assign wr = accept && (col_ptr == PW'(c));

`ifdef STORE_ARRAY_SHADOW_EN
    store_array_col #(.ROWS(ROWS)) u_shadow (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .we    (wr),
      .d     (dat),
      .q     (shadow_q[c])
    );

    // Visible column only moves when the whole frame is committed.
    store_array_col #(.ROWS(ROWS)) u_out (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .we    (commit),
      .d     (shadow_q[c]),
      .q     (col_q[c])
    );
`else
    store_array_col #(.ROWS(ROWS)) u_out (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .we    (wr),
      .d     (dat),
      .q     (col_q[c])
    );
`endif
  end

  always_comb begin
    out = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        out[bit_idx(r, c, COLS)] = col_q[c][r];
      end
    end
  end

endmodule

// File: tb/tb_store_array.sv
// Directed bench for store_array: 2x2, 4x3 and 2x1 instances, inline checks plus
// a commit scoreboard that compares out on the cycle after each load_done pulse.
module tb_store_array;
  import store_array_pkg::*;

`ifdef STORE_ARRAY_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 2x2 ----------------
  logic [1:0]  a_dat = '0;
  logic        a_valid = 1'b0, a_restart = 1'b0, a_clr = 1'b0;
  logic        a_ready, a_done;
  logic [0:0]  a_ptr;
  logic [3:0]  a_out;
  state_t      a_st;

  store_array #(.ROWS(2), .COLS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .dat(a_dat), .dat_valid(a_valid), .dat_ready(a_ready),
    .restart(a_restart), .clr(a_clr), .col_ptr(a_ptr), .load_done(a_done),
    .out(a_out), .state_dbg(a_st)
  );

  // ---------------- DUT B: 4x3 ----------------
  logic [3:0]  b_dat = '0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_done;
  logic [1:0]  b_ptr;
  logic [11:0] b_out;
  state_t      b_st;

  store_array #(.ROWS(4), .COLS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .dat(b_dat), .dat_valid(b_valid), .dat_ready(b_ready),
    .restart(1'b0), .clr(1'b0), .col_ptr(b_ptr), .load_done(b_done),
    .out(b_out), .state_dbg(b_st)
  );

  // ---------------- DUT C: 2x1 ----------------
  logic [1:0]  c_dat = '0;
  logic        c_valid = 1'b0;
  logic        c_ready, c_done;
  logic [0:0]  c_ptr;
  logic [1:0]  c_out;
  state_t      c_st;

  store_array #(.ROWS(2), .COLS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .dat(c_dat), .dat_valid(c_valid), .dat_ready(c_ready),
    .restart(1'b0), .clr(1'b0), .col_ptr(c_ptr), .load_done(c_done),
    .out(c_out), .state_dbg(c_st)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [3:0]  exp_a[$];
  logic [11:0] exp_b[$];
  logic [1:0]  exp_c[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A commit is judged one cycle after load_done, when out must hold the full frame.
  logic pend_a = 1'b0, pend_b = 1'b0, pend_c = 1'b0;
  always @(negedge clk) begin
    if (pend_a) begin
      if (exp_a.size() == 0) check("a_unexpected_commit", 16'd1, 16'd0);
      else check("a_commit_out", 16'(a_out), 16'(exp_a.pop_front()));
    end
    if (pend_b) begin
      if (exp_b.size() == 0) check("b_unexpected_commit", 16'd1, 16'd0);
      else check("b_commit_out", 16'(b_out), 16'(exp_b.pop_front()));
    end
    if (pend_c) begin
      if (exp_c.size() == 0) check("c_unexpected_commit", 16'd1, 16'd0);
      else check("c_commit_out", 16'(c_out), 16'(exp_c.pop_front()));
    end
    pend_a = rst_n && !a_clr && a_done;
    pend_b = rst_n && b_done;
    pend_c = rst_n && c_done;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check("rst_a_out", 16'(a_out), 16'h0);
    check("rst_a_ptr", 16'(a_ptr), 16'h0);
    check("rst_a_done", 16'(a_done), 16'h0);
    check("rst_a_ready", 16'(a_ready), 16'h1);
    check("rst_b_out", 16'(b_out), 16'h0);
    check("rst_c_out", 16'(c_out), 16'h0);
    a_restart = 1'b1;
    #1;
    check("ready_follows_restart", 16'(a_ready), 16'h0);
    a_restart = 1'b0;
    rst_n = 1'b1;
    tick();

    // Frame 1: 01,01 -> rows0 of both columns -> 0011; valid held into frame 2
    exp_a.push_back(4'b0011);
    a_valid = 1'b1; a_dat = 2'b01;
    tick();
    check("f1_ptr1", 16'(a_ptr), 16'h1);
    check("f1_out_mid", 16'(a_out), SHADOW ? 16'h0 : 16'h1);
    check("f1_done_mid", 16'(a_done), 16'h0);
    a_dat = 2'b01;
    tick();
    check("f1_done", 16'(a_done), 16'h1);
    check("f1_commit_ready", 16'(a_ready), 16'h0);
    check("f1_commit_state", 16'(a_st), 16'(ST_COMMIT));
    check("f1_commit_ptr", 16'(a_ptr), 16'h0);
    check("f1_out_commit", 16'(a_out), SHADOW ? 16'h0 : 16'h3);
    a_dat = 2'b10;
    tick();
    check("f1_done_once", 16'(a_done), 16'h0);
    check("bp_ptr_not_moved", 16'(a_ptr), 16'h0);
    check("bp_ready_back", 16'(a_ready), 16'h1);
    check("f1_out_after", 16'(a_out), 16'h3);

    // Frame 2: 10,11 -> bit2 (r1c0), bits1,3 (c1) -> 1110
    exp_a.push_back(4'b1110);
    tick();
    check("f2_ptr1", 16'(a_ptr), 16'h1);
    check("f2_out_mid", 16'(a_out), SHADOW ? 16'h3 : 16'h6);
    a_dat = 2'b11;
    tick();
    check("f2_done", 16'(a_done), 16'h1);
    a_valid = 1'b0;
    tick();
    check("f2_out", 16'(a_out), 16'hE);

    // Restart after one beat of 11
    a_valid = 1'b1; a_dat = 2'b11;
    tick();
    check("rs_ptr1", 16'(a_ptr), 16'h1);
    a_valid = 1'b0; a_restart = 1'b1;
    tick();
    check("rs_ptr0", 16'(a_ptr), 16'h0);
    check("rs_done", 16'(a_done), 16'h0);
    a_restart = 1'b0;
    tick();
    check("rs_done_still", 16'(a_done), 16'h0);
    check("rs_out", 16'(a_out), SHADOW ? 16'hE : 16'hF);

    // Frame 3: 10,01 -> bit2 (r1c0) + bit1 (r0c1) = 0110; restart during COMMIT ignored
    exp_a.push_back(4'b0110);
    a_valid = 1'b1; a_dat = 2'b10;
    tick();
    a_dat = 2'b01;
    tick();
    check("f3_done", 16'(a_done), 16'h1);
    a_valid = 1'b0; a_restart = 1'b1;
    tick();
    check("f3_back_to_load", 16'(a_st), 16'(ST_LOAD));
    a_restart = 1'b0;
    tick();
    check("f3_out", 16'(a_out), 16'h6);

    // clr mid-frame with a beat offered
    a_valid = 1'b1; a_dat = 2'b11;
    tick();
    check("clr_pre_ptr", 16'(a_ptr), 16'h1);
    a_clr = 1'b1;
    tick();
    check("clr_out", 16'(a_out), 16'h0);
    check("clr_ptr", 16'(a_ptr), 16'h0);
    check("clr_done", 16'(a_done), 16'h0);
    a_clr = 1'b0; a_valid = 1'b0;
    tick();
    check("clr_out_hold", 16'(a_out), 16'h0);

    // rst_n low during COMMIT
    a_valid = 1'b1; a_dat = 2'b01;
    tick();
    a_dat = 2'b11;
    tick();
    check("rc_done", 16'(a_done), 16'h1);
    a_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("rc_out", 16'(a_out), 16'h0);
    check("rc_ptr", 16'(a_ptr), 16'h0);
    check("rc_done_low", 16'(a_done), 16'h0);
    check("rc_ready", 16'(a_ready), 16'h1);
    rst_n = 1'b1;
    tick();

    // Frame 4 after reset: 10,10 -> bits 2,3 -> 1100
    exp_a.push_back(4'b1100);
    a_valid = 1'b1; a_dat = 2'b10;
    tick();
    tick();
    a_valid = 1'b0;
    tick();
    tick();

    // DUT B 4x3: A,5,F -> bits 3,9 | 1,7 | 2,5,8,11 = 12'hBAE
    exp_b.push_back(12'hBAE);
    check("b_ptr0", 16'(b_ptr), 16'h0);
    b_valid = 1'b1; b_dat = 4'hA;
    tick();
    check("b_ptr1", 16'(b_ptr), 16'h1);
    b_dat = 4'h5;
    tick();
    check("b_ptr2", 16'(b_ptr), 16'h2);
    b_dat = 4'hF;
    tick();
    check("b_ptr_wrap", 16'(b_ptr), 16'h0);
    check("b_done", 16'(b_done), 16'h1);
    b_valid = 1'b0;
    tick();
    check("b_done_low", 16'(b_done), 16'h0);
    tick();

    // DUT C 2x1: every beat commits
    exp_c.push_back(2'b10);
    exp_c.push_back(2'b01);
    c_valid = 1'b1; c_dat = 2'b10;
    tick();
    check("c_done1", 16'(c_done), 16'h1);
    check("c_ready_commit", 16'(c_ready), 16'h0);
    c_dat = 2'b01;
    tick();
    check("c_done1_low", 16'(c_done), 16'h0);
    tick();
    check("c_done2", 16'(c_done), 16'h1);
    c_valid = 1'b0;
    tick();
    check("c_done2_low", 16'(c_done), 16'h0);
    tick();
    tick();

    check("a_queue_drained", 16'(exp_a.size()), 16'h0);
    check("b_queue_drained", 16'(exp_b.size()), 16'h0);
    check("c_queue_drained", 16'(exp_c.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
